// File: rtl/multi_hero_input_ctrl.sv
// PS/2 set-2 keyboard decoder that tracks held direction keys per hero and,
// on request, computes clamped next positions for every hero in one pulse.
module multi_hero_input_ctrl #(
  parameter int COORD_W   = 9,
  parameter int N_PLAYERS = 2,
  parameter int STEP      = 1,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 319,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 239
) (
  input  logic                           CLOCK_50,
  input  logic                           RESET_H,
  input  logic [7:0]                     SCAN_CODE,
  input  logic                           SCAN_VALID,
  input  logic                           GET_INPUT,
  input  logic [N_PLAYERS*COORD_W-1:0]   CURR_POS_X,
  input  logic [N_PLAYERS*COORD_W-1:0]   CURR_POS_Y,
  output logic [N_PLAYERS*COORD_W-1:0]   HERO_NEW_X,
  output logic [N_PLAYERS*COORD_W-1:0]   HERO_NEW_Y,
  output logic                           MOVE_VALID,
  output logic                           BUSY,
  output logic [2*N_PLAYERS-1:0]         FACING,
  output logic [4*N_PLAYERS-1:0]         KEYS_HELD
);

  // Two guard bits: one for sign, one so an out-of-range position plus STEP cannot wrap.
  localparam int AW = COORD_W + 2;
  localparam int PW = N_PLAYERS * COORD_W;

  typedef enum logic [1:0] {PF_IDLE, PF_EXT, PF_BRK, PF_EXT_BRK} pfx_t;
  typedef enum logic [1:0] {RQ_IDLE, RQ_CALC, RQ_DONE} req_t;

  pfx_t r_pfx, w_pfx_next;
  req_t r_req, w_req_next;

  logic                   w_evt, w_evt_ext, w_evt_brk;
  logic                   w_hit, w_ply;
  logic [1:0]             w_bit, w_dir;
  logic [4*N_PLAYERS-1:0] w_key_mask;
  logic [2*N_PLAYERS-1:0] w_face_mask, w_face_val;

  logic [4*N_PLAYERS-1:0] r_keys;
  logic [2*N_PLAYERS-1:0] r_facing;

  logic [PW-1:0]          r_snap_x_p0, r_snap_y_p0;
  logic [4*N_PLAYERS-1:0] r_snap_keys_p0;

  logic [PW-1:0]          w_calc_x, w_calc_y;
  logic [3:0]             w_keys_n;
  logic signed [AW-1:0]   w_sum_x, w_sum_y;

  logic [PW-1:0]          r_new_x_p1, r_new_y_p1;
  logic                   r_vld_p1;

  function automatic logic signed [AW-1:0] axis_step(input logic inc, input logic dec);
    logic signed [AW-1:0] s;
    s = AW'(STEP);
    if (inc && !dec) return s;
    if (dec && !inc) return -s;
    return '0;
  endfunction

  function automatic logic [COORD_W-1:0] sat_coord(input logic signed [AW-1:0] v,
                                                    input int lo, input int hi);
    logic signed [AW-1:0] lo_s, hi_s;
    lo_s = AW'(lo);
    hi_s = AW'(hi);
    if (v < lo_s) return lo_s[COORD_W-1:0];
    if (v > hi_s) return hi_s[COORD_W-1:0];
    return v[COORD_W-1:0];
  endfunction

  // Prefix tracking: E0/F0 bytes only steer state; any other byte is a key event.
  always_comb begin
    w_pfx_next = r_pfx;
    w_evt      = 1'b0;
    w_evt_ext  = 1'b0;
    w_evt_brk  = 1'b0;
    if (SCAN_VALID) begin
      unique case (r_pfx)
        PF_IDLE: begin
          if (SCAN_CODE == 8'hE0)      w_pfx_next = PF_EXT;
          else if (SCAN_CODE == 8'hF0) w_pfx_next = PF_BRK;
          else begin
            w_evt      = 1'b1;
            w_pfx_next = PF_IDLE;
          end
        end
        PF_EXT: begin
          if (SCAN_CODE == 8'hF0)      w_pfx_next = PF_EXT_BRK;
          else if (SCAN_CODE == 8'hE0) w_pfx_next = PF_EXT;
          else begin
            w_evt      = 1'b1;
            w_evt_ext  = 1'b1;
            w_pfx_next = PF_IDLE;
          end
        end
        PF_BRK: begin
          if (SCAN_CODE == 8'hE0) w_pfx_next = PF_EXT_BRK;
          else begin
            w_evt      = 1'b1;
            w_evt_brk  = 1'b1;
            w_pfx_next = PF_IDLE;
          end
        end
        PF_EXT_BRK: begin
          w_evt      = 1'b1;
          w_evt_ext  = 1'b1;
          w_evt_brk  = 1'b1;
          w_pfx_next = PF_IDLE;
        end
        default: w_pfx_next = PF_IDLE;
      endcase
    end
  end

  // Key decode; bit index follows the {up,left,down,right} bitmap layout.
  always_comb begin
    w_hit = 1'b0;
    w_ply = 1'b0;
    w_bit = 2'd0;
    if (!w_evt_ext) begin
      unique case (SCAN_CODE)
        8'h1D: begin w_hit = 1'b1; w_bit = 2'd3; end
        8'h1C: begin w_hit = 1'b1; w_bit = 2'd2; end
        8'h1B: begin w_hit = 1'b1; w_bit = 2'd1; end
        8'h23: begin w_hit = 1'b1; w_bit = 2'd0; end
        default: w_hit = 1'b0;
      endcase
    end else begin
      unique case (SCAN_CODE)
        8'h75: begin w_hit = 1'b1; w_bit = 2'd3; end
        8'h6B: begin w_hit = 1'b1; w_bit = 2'd2; end
        8'h72: begin w_hit = 1'b1; w_bit = 2'd1; end
        8'h74: begin w_hit = 1'b1; w_bit = 2'd0; end
        default: w_hit = 1'b0;
      endcase
      w_ply = w_hit && (N_PLAYERS == 2);
    end

    unique case (w_bit)
      2'd3:    w_dir = 2'b00;
      2'd2:    w_dir = 2'b11;
      2'd1:    w_dir = 2'b10;
      default: w_dir = 2'b01;
    endcase

    w_key_mask       = '0;
    w_key_mask[0]    = w_hit && w_evt;
    w_key_mask       = w_key_mask << {w_ply, w_bit};
    w_face_mask      = '0;
    w_face_mask[1:0] = {2{w_hit && w_evt && !w_evt_brk}};
    w_face_mask      = w_face_mask << {w_ply, 1'b0};
    w_face_val       = {N_PLAYERS{w_dir}};
  end

  always_comb begin
    w_req_next = r_req;
    unique case (r_req)
      RQ_IDLE: if (GET_INPUT) w_req_next = RQ_CALC;
      RQ_CALC: w_req_next = RQ_DONE;
      RQ_DONE: w_req_next = RQ_IDLE;
      default: w_req_next = RQ_IDLE;
    endcase
  end

  // Stage p0: snapshot taken on the accepting edge, before that edge's key event lands.
  always_ff @(posedge CLOCK_50) begin
    if (r_req == RQ_IDLE && GET_INPUT) begin
      r_snap_x_p0    <= CURR_POS_X;
      r_snap_y_p0    <= CURR_POS_Y;
      r_snap_keys_p0 <= r_keys;
    end
  end

  always_comb begin
    w_calc_x = '0;
    w_calc_y = '0;
    w_keys_n = '0;
    w_sum_x  = '0;
    w_sum_y  = '0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      w_keys_n = r_snap_keys_p0[4*p +: 4];
      w_sum_x  = $signed({2'b00, r_snap_x_p0[p*COORD_W +: COORD_W]})
                 + axis_step(w_keys_n[0], w_keys_n[2]);
      w_sum_y  = $signed({2'b00, r_snap_y_p0[p*COORD_W +: COORD_W]})
                 + axis_step(w_keys_n[1], w_keys_n[3]);
      w_calc_x[p*COORD_W +: COORD_W] = sat_coord(w_sum_x, X_MIN, X_MAX);
      w_calc_y[p*COORD_W +: COORD_W] = sat_coord(w_sum_y, Y_MIN, Y_MAX);
    end
  end

  // Stage p1: registered results with their one-cycle valid.
  always_ff @(posedge CLOCK_50) begin
    if (RESET_H) begin
      r_pfx      <= PF_IDLE;
      r_req      <= RQ_IDLE;
      r_keys     <= '0;
      r_facing   <= {N_PLAYERS{2'b10}};
      r_vld_p1   <= 1'b0;
      r_new_x_p1 <= '0;
      r_new_y_p1 <= '0;
    end else begin
      r_pfx    <= w_pfx_next;
      r_req    <= w_req_next;
      r_vld_p1 <= (r_req == RQ_CALC);
      if (r_req == RQ_CALC) begin
        r_new_x_p1 <= w_calc_x;
        r_new_y_p1 <= w_calc_y;
      end
      if (w_evt) begin
        if (w_evt_brk) r_keys <= r_keys & ~w_key_mask;
        else           r_keys <= r_keys | w_key_mask;
      end
      r_facing <= (r_facing & ~w_face_mask) | (w_face_val & w_face_mask);
    end
  end

  assign HERO_NEW_X = r_new_x_p1;
  assign HERO_NEW_Y = r_new_y_p1;
  assign MOVE_VALID = r_vld_p1;
  assign BUSY       = (r_req != RQ_IDLE);
  assign FACING     = r_facing;
  assign KEYS_HELD  = r_keys;

endmodule

// File: tb/tb_multi_hero_input_ctrl.sv
// Directed bench: a two-player STEP=1 instance and a one-player STEP=4 instance share stimulus.
module tb_multi_hero_input_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  code;
  logic        sv;
  logic        get;
  logic [17:0] pos_x, pos_y, new_x, new_y;
  logic        mv, busy;
  logic [3:0]  facing;
  logic [7:0]  keys;
  logic [8:0]  pos_x4, pos_y4, new_x4, new_y4;
  logic        mv4, busy4;
  logic [1:0]  facing4;
  logic [3:0]  keys4;

  int n_checks = 0;
  int n_err    = 0;
  int mv_cnt;
  logic [8:0] cap_y, cap_y4;

  always #5 clk = ~clk;

  multi_hero_input_ctrl u_dut (
    .CLOCK_50(clk), .RESET_H(rst), .SCAN_CODE(code), .SCAN_VALID(sv), .GET_INPUT(get),
    .CURR_POS_X(pos_x), .CURR_POS_Y(pos_y), .HERO_NEW_X(new_x), .HERO_NEW_Y(new_y),
    .MOVE_VALID(mv), .BUSY(busy), .FACING(facing), .KEYS_HELD(keys)
  );

  multi_hero_input_ctrl #(.N_PLAYERS(1), .STEP(4)) u_dut4 (
    .CLOCK_50(clk), .RESET_H(rst), .SCAN_CODE(code), .SCAN_VALID(sv), .GET_INPUT(get),
    .CURR_POS_X(pos_x4), .CURR_POS_Y(pos_y4), .HERO_NEW_X(new_x4), .HERO_NEW_Y(new_y4),
    .MOVE_VALID(mv4), .BUSY(busy4), .FACING(facing4), .KEYS_HELD(keys4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    code = b;
    sv   = 1'b1;
    tick();
    sv   = 1'b0;
  endtask

  task automatic set_pos(input logic [8:0] x0, input logic [8:0] y0,
                         input logic [8:0] x1, input logic [8:0] y1);
    pos_x  = {x1, x0};
    pos_y  = {y1, y0};
    pos_x4 = x0;
    pos_y4 = y0;
  endtask

  // Leaves the bench one cycle after acceptance, i.e. in the MOVE_VALID cycle.
  task automatic request();
    get = 1'b1;
    tick();
    get = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; code = 8'h00; sv = 1'b0; get = 1'b0;
    set_pos(9'd0, 9'd0, 9'd0, 9'd0);
    tick(); tick(); tick();
    chk("rst_mv", 32'(mv), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_keys", 32'(keys), 32'h00);
    chk("rst_facing", 32'(facing), 32'b1010);
    chk("rst_newx", 32'(new_x), 32'd0);
    chk("rst_newy", 32'(new_y), 32'd0);
    chk("rst_facing4", 32'(facing4), 32'b10);
    rst = 1'b0;

    // Right key for P0, one request
    send(8'h23);
    chk("s1_keys", 32'(keys), 32'h01);
    chk("s1_facing", 32'(facing), 32'b1001);
    set_pos(9'd100, 9'd50, 9'd200, 9'd20);
    get = 1'b1;
    tick();
    get = 1'b0;
    chk("s1_busy_k", 32'(busy), 32'd1);
    chk("s1_mv_k", 32'(mv), 32'd0);
    tick();
    chk("s1_mv", 32'(mv), 32'd1);
    chk("s1_busy_k1", 32'(busy), 32'd1);
    chk("s1_p0x", 32'(new_x[8:0]), 32'd101);
    chk("s1_p0y", 32'(new_y[8:0]), 32'd50);
    chk("s1_p1x", 32'(new_x[17:9]), 32'd200);
    chk("s1_p1y", 32'(new_y[17:9]), 32'd20);
    chk("s1_p0x_step4", 32'(new_x4), 32'd104);
    tick();
    chk("s1_mv_off", 32'(mv), 32'd0);
    chk("s1_busy_off", 32'(busy), 32'd0);
    chk("s1_hold", 32'(new_x[8:0]), 32'd101);
    send(8'hF0); send(8'h23);
    chk("s1_release", 32'(keys), 32'h00);

    // P1 up arrow: make then break
    send(8'hE0); send(8'h75);
    chk("s2_keys_make", 32'(keys), 32'h80);
    chk("s2_keys4_make", 32'(keys4), 32'h8);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("s2_keys_brk", 32'(keys[7:4]), 32'h0);
    chk("s2_facing_p1", 32'(facing[3:2]), 32'b00);
    set_pos(9'd100, 9'd50, 9'd10, 9'd10);
    request();
    chk("s2_p1x", 32'(new_x[17:9]), 32'd10);
    chk("s2_p1y", 32'(new_y[17:9]), 32'd10);
    tick();

    // Keypad codes and stray breaks leave the bitmap alone
    send(8'h75);
    chk("kp_ignored", 32'(keys), 32'h00);
    send(8'hF0); send(8'h1B);
    chk("brk_not_held", 32'(keys), 32'h00);
    chk("brk_not_held_face", 32'(facing), 32'b0001);

    // Left+right cancel, up clamped at Y_MIN
    send(8'h1C); send(8'h23); send(8'h1D);
    chk("s3_keys", 32'(keys), 32'h0D);
    chk("s3_facing", 32'(facing), 32'b0000);
    set_pos(9'd5, 9'd0, 9'd30, 9'd30);
    request();
    chk("s3_p0x", 32'(new_x[8:0]), 32'd5);
    chk("s3_p0y", 32'(new_y[8:0]), 32'd0);
    chk("s3_p0y_step4", 32'(new_y4), 32'd0);
    tick();
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h23); send(8'hF0); send(8'h1D);
    chk("s3_release", 32'(keys), 32'h00);

    // Clamp at X_MAX and X_MIN, and pull-back of out-of-range positions
    send(8'h23);
    set_pos(9'd319, 9'd100, 9'd0, 9'd0);
    request();
    chk("s4_xmax", 32'(new_x[8:0]), 32'd319);
    chk("s4_xmax_step4", 32'(new_x4), 32'd319);
    tick();
    send(8'hF0); send(8'h23); send(8'h1C);
    set_pos(9'd2, 9'd100, 9'd0, 9'd0);
    request();
    chk("s4_xmin", 32'(new_x[8:0]), 32'd1);
    chk("s4_xmin_step4", 32'(new_x4), 32'd0);
    tick();
    set_pos(9'd400, 9'd300, 9'd0, 9'd0);
    request();
    chk("s4_oob_x", 32'(new_x[8:0]), 32'd319);
    chk("s4_oob_y", 32'(new_y[8:0]), 32'd239);
    chk("s4_oob_x4", 32'(new_x4), 32'd319);
    tick();
    send(8'hF0); send(8'h1C);

    // Break lands on the accepting edge; GET_INPUT held through CALC and DONE
    send(8'h1B);
    set_pos(9'd100, 9'd50, 9'd0, 9'd0);
    send(8'hF0);
    code = 8'h1B; sv = 1'b1; get = 1'b1;
    tick();
    sv = 1'b0;
    mv_cnt = 0;
    cap_y = 9'd0; cap_y4 = 9'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 1) get = 1'b0;
      if (mv) begin
        mv_cnt++;
        cap_y  = new_y[8:0];
        cap_y4 = new_y4;
      end
    end
    chk("s5_one_pulse", 32'(mv_cnt), 32'd1);
    chk("s5_pre_event_y", 32'(cap_y), 32'd51);
    chk("s5_pre_event_y4", 32'(cap_y4), 32'd54);
    chk("s5_keys_cleared", 32'(keys), 32'h00);

    // Reset in CALC abandons the request
    send(8'h1D);
    chk("s6_keys", 32'(keys), 32'h08);
    get = 1'b1;
    tick();
    chk("s6_busy_calc", 32'(busy), 32'd1);
    get = 1'b0;
    rst = 1'b1;
    tick();
    chk("s6_mv", 32'(mv), 32'd0);
    chk("s6_busy", 32'(busy), 32'd0);
    chk("s6_keys_clr", 32'(keys), 32'h00);
    chk("s6_facing", 32'(facing), 32'b1010);
    chk("s6_newx", 32'(new_x), 32'd0);
    chk("s6_newy", 32'(new_y), 32'd0);
    get = 1'b1;
    tick();
    chk("s6_get_in_rst", 32'(busy), 32'd0);
    get = 1'b0;
    rst = 1'b0;
    code = 8'h23; sv = 1'b1;
    tick();
    sv = 1'b0;
    chk("s6_no_late_mv", 32'(mv), 32'd0);
    chk("s6_first_edge_key", 32'(keys), 32'h01);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
